// File: rtl/max_argmax_pipe_if.sv
// Handshake bundle for max_argmax_pipe: sample in (valid/ready/data/tag), result out (valid/ready/data/tag).
// MAX_ARGMAX_EN adds the o_index result field.
interface max_argmax_pipe_if #(
  parameter int DATA_WIDTH = 16,
  parameter int CHANNELS   = 4,
  parameter int TAG_WIDTH  = 8
);
`ifdef MAX_ARGMAX_EN
  localparam int IDX_W = (CHANNELS <= 1) ? 1 : $clog2(CHANNELS);
`endif

  logic                           i_valid;
  logic                           i_ready;
  logic [DATA_WIDTH*CHANNELS-1:0] i_data;
  logic [TAG_WIDTH-1:0]           i_tag;
  logic                           o_valid;
  logic                           o_ready;
  logic [DATA_WIDTH-1:0]          o_data;
  logic [TAG_WIDTH-1:0]           o_tag;
`ifdef MAX_ARGMAX_EN
  logic [IDX_W-1:0]               o_index;
`endif

  modport master (
`ifdef MAX_ARGMAX_EN
    input  o_index,
`endif
    output i_valid, i_data, i_tag, o_ready,
    input  i_ready, o_valid, o_data, o_tag
  );

  modport slave (
`ifdef MAX_ARGMAX_EN
    output o_index,
`endif
    input  i_valid, i_data, i_tag, o_ready,
    output i_ready, o_valid, o_data, o_tag
  );
endinterface

// File: rtl/max_argmax_pipe.sv
// Pipelined max-reduction tree over CHANNELS values with valid/ready handshake and tag sideband.
// Define MAX_ARGMAX_EN to also carry the winning channel index through the tree (o_index).
module max_argmax_pipe #(
  parameter int DATA_WIDTH = 16,
  parameter int CHANNELS   = 4,
  parameter int SIGNED     = 1,
  parameter int TAG_WIDTH  = 8
) (
  input logic              clk,
  input logic              rst_n,
  max_argmax_pipe_if.slave bus
);
  localparam int STAGES = (CHANNELS <= 1) ? 1 : $clog2(CHANNELS);
`ifdef MAX_ARGMAX_EN
  localparam int IDX_W  = (CHANNELS <= 1) ? 1 : $clog2(CHANNELS);
`endif

  logic [DATA_WIDTH-1:0] st_data  [1:STAGES][CHANNELS];
  logic [DATA_WIDTH-1:0] nxt_data [1:STAGES][CHANNELS];
`ifdef MAX_ARGMAX_EN
  logic [IDX_W-1:0]      st_idx   [1:STAGES][CHANNELS];
  logic [IDX_W-1:0]      nxt_idx  [1:STAGES][CHANNELS];
`endif
  logic [TAG_WIDTH-1:0]  st_tag   [1:STAGES];
  logic [STAGES:1]       st_valid;
  logic                  stall;

  // Right operand wins only when strictly greater, so ties keep the lower channel.
  function automatic logic right_wins(input logic [DATA_WIDTH-1:0] a,
                                      input logic [DATA_WIDTH-1:0] b);
    if (SIGNED != 0) return $signed(b) > $signed(a);
    else             return b > a;
  endfunction

  assign stall       = st_valid[STAGES] & ~bus.o_ready;
  assign bus.i_ready = ~stall;
  assign bus.o_valid = st_valid[STAGES];
  assign bus.o_data  = st_data[STAGES][0];
  assign bus.o_tag   = st_tag[STAGES];
`ifdef MAX_ARGMAX_EN
  assign bus.o_index = st_idx[STAGES][0];
`endif

  // cur holds the previous level's elements: the raw input for level 1, then each registered level.
  always_comb begin : tree_comb
    logic [DATA_WIDTH-1:0] cur_d [CHANNELS];
`ifdef MAX_ARGMAX_EN
    logic [IDX_W-1:0]      cur_i [CHANNELS];
`endif
    int unsigned n;
    int unsigned r;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      cur_d[k] = bus.i_data[k*DATA_WIDTH +: DATA_WIDTH];
`ifdef MAX_ARGMAX_EN
      cur_i[k] = IDX_W'(k);
`endif
    end
    n = CHANNELS;
    for (int unsigned s = 1; s <= STAGES; s++) begin
      for (int unsigned j = 0; j < CHANNELS; j++) begin
        nxt_data[s][j] = '0;
`ifdef MAX_ARGMAX_EN
        nxt_idx[s][j]  = '0;
`endif
      end
      for (int unsigned j = 0; j < (CHANNELS + 1) / 2; j++) begin
        r = (2*j + 1 < CHANNELS) ? 2*j + 1 : 2*j;
        if (2*j + 1 < n) begin
          if (right_wins(cur_d[2*j], cur_d[r])) begin
            nxt_data[s][j] = cur_d[r];
`ifdef MAX_ARGMAX_EN
            nxt_idx[s][j]  = cur_i[r];
`endif
          end else begin
            nxt_data[s][j] = cur_d[2*j];
`ifdef MAX_ARGMAX_EN
            nxt_idx[s][j]  = cur_i[2*j];
`endif
          end
        end else if (2*j < n) begin
          nxt_data[s][j] = cur_d[2*j];
`ifdef MAX_ARGMAX_EN
          nxt_idx[s][j]  = cur_i[2*j];
`endif
        end
      end
      n = (n + 1) / 2;
      for (int unsigned k = 0; k < CHANNELS; k++) begin
        cur_d[k] = st_data[s][k];
`ifdef MAX_ARGMAX_EN
        cur_i[k] = st_idx[s][k];
`endif
      end
    end
  end

  // A single stall enable freezes every stage; bubbles advance like data otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_valid <= '0;
      for (int unsigned s = 1; s <= STAGES; s++) begin
        st_tag[s] <= '0;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
          st_data[s][k] <= '0;
`ifdef MAX_ARGMAX_EN
          st_idx[s][k]  <= '0;
`endif
        end
      end
    end else if (!stall) begin
      st_valid[1] <= bus.i_valid;
      st_tag[1]   <= bus.i_tag;
      for (int unsigned s = 2; s <= STAGES; s++) begin
        st_valid[s] <= st_valid[s-1];
        st_tag[s]   <= st_tag[s-1];
      end
      for (int unsigned s = 1; s <= STAGES; s++) begin
        for (int unsigned k = 0; k < CHANNELS; k++) begin
          st_data[s][k] <= nxt_data[s][k];
`ifdef MAX_ARGMAX_EN
          st_idx[s][k]  <= nxt_idx[s][k];
`endif
        end
      end
    end
  end
endmodule

// File: tb/tb_max_argmax_pipe.sv
// Directed bench for max_argmax_pipe: 4-ch signed, 4-ch unsigned and 5-ch signed instances.
// Index checks are active only when MAX_ARGMAX_EN is defined.
module tb_max_argmax_pipe;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  max_argmax_pipe_if #(.DATA_WIDTH(16), .CHANNELS(4), .TAG_WIDTH(8)) s4 ();
  max_argmax_pipe_if #(.DATA_WIDTH(16), .CHANNELS(4), .TAG_WIDTH(8)) u4 ();
  max_argmax_pipe_if #(.DATA_WIDTH(16), .CHANNELS(5), .TAG_WIDTH(8)) f5 ();

  max_argmax_pipe #(.DATA_WIDTH(16), .CHANNELS(4), .SIGNED(1), .TAG_WIDTH(8))
    dut_s4 (.clk(clk), .rst_n(rst_n), .bus(s4.slave));
  max_argmax_pipe #(.DATA_WIDTH(16), .CHANNELS(4), .SIGNED(0), .TAG_WIDTH(8))
    dut_u4 (.clk(clk), .rst_n(rst_n), .bus(u4.slave));
  max_argmax_pipe #(.DATA_WIDTH(16), .CHANNELS(5), .SIGNED(1), .TAG_WIDTH(8))
    dut_f5 (.clk(clk), .rst_n(rst_n), .bus(f5.slave));

  int errors = 0;
  int checks = 0;

  logic [63:0] vec     [8];
  logic [15:0] exp_d   [8];
  logic [1:0]  exp_i   [8];
  logic [15:0] q_d [$];
  logic [7:0]  q_t [$];
  logic [1:0]  q_i [$];
  int          sent, rcvd, cyc;
  logic        stall_prev, exp_rdy;
  logic [15:0] held_d;
  logic [7:0]  held_t;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] pack4(input logic [15:0] c3, input logic [15:0] c2,
                                        input logic [15:0] c1, input logic [15:0] c0);
    return {c3, c2, c1, c0};
  endfunction

  initial begin
    vec[0] = pack4(16'd1, 16'd2, 16'd3, 16'd4);             exp_d[0] = 16'd4;      exp_i[0] = 2'd0;
    vec[1] = pack4(16'd10, 16'hFFFF, 16'hFFFE, 16'hFFFD);   exp_d[1] = 16'd10;     exp_i[1] = 2'd3;
    vec[2] = pack4(16'hFFFB, 16'hFFFA, 16'hFFFC, 16'hFFF9); exp_d[2] = 16'hFFFC;   exp_i[2] = 2'd1;
    vec[3] = pack4(16'd0, 16'd0, 16'd0, 16'd0);             exp_d[3] = 16'd0;      exp_i[3] = 2'd0;
    vec[4] = pack4(16'h7FFF, 16'h8000, 16'd5, 16'd5);       exp_d[4] = 16'h7FFF;   exp_i[4] = 2'd3;
    vec[5] = pack4(16'd3, 16'd8, 16'd8, 16'd3);             exp_d[5] = 16'd8;      exp_i[5] = 2'd1;
    vec[6] = pack4(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFE); exp_d[6] = 16'hFFFF;   exp_i[6] = 2'd1;
    vec[7] = pack4(16'd100, 16'd200, 16'd300, 16'd400);     exp_d[7] = 16'd400;    exp_i[7] = 2'd0;

    // Reset with i_valid asserted: nothing may be emitted
    rst_n = 1'b0;
    s4.i_valid = 1'b1; s4.i_data = 64'h1234_5678_9ABC_DEF0; s4.i_tag = 8'h5A; s4.o_ready = 1'b1;
    u4.i_valid = 1'b1; u4.i_data = 64'h1234_5678_9ABC_DEF0; u4.i_tag = 8'h5A; u4.o_ready = 1'b1;
    f5.i_valid = 1'b1; f5.i_data = 80'h0; f5.i_tag = 8'h5A; f5.o_ready = 1'b1;
    #1;
    chk("rst_o_valid", s4.o_valid, 0);
    chk("rst_o_data", s4.o_data, 0);
    chk("rst_o_tag", s4.o_tag, 0);
    chk("rst_i_ready", s4.i_ready, 1);
`ifdef MAX_ARGMAX_EN
    chk("rst_o_index", s4.o_index, 0);
`endif
    repeat (3) begin
      tick();
      chk("rst_hold_s4_valid", s4.o_valid, 0);
      chk("rst_hold_f5_valid", f5.o_valid, 0);
    end
    s4.i_valid = 1'b0; u4.i_valid = 1'b0; f5.i_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("post_rst_idle", s4.o_valid, 0);

    // Signed 4-ch basic: {-3,7,2,-8}, two-cycle latency
    s4.i_data = pack4(16'hFFFD, 16'd7, 16'd2, 16'hFFF8); s4.i_tag = 8'h11; s4.i_valid = 1'b1;
    tick();
    s4.i_valid = 1'b0;
    chk("basic_lat_early", s4.o_valid, 0);
    tick();
    chk("basic_valid", s4.o_valid, 1);
    chk("basic_data", s4.o_data, 16'd7);
    chk("basic_tag", s4.o_tag, 8'h11);
`ifdef MAX_ARGMAX_EN
    chk("basic_index", s4.o_index, 2);
`endif
    tick();
    chk("basic_single", s4.o_valid, 0);

    // Signed vs unsigned with ch1 = 0x8000
    s4.i_data = pack4(16'd1, 16'd1, 16'h8000, 16'd1); s4.i_tag = 8'h22; s4.i_valid = 1'b1;
    u4.i_data = pack4(16'd1, 16'd1, 16'h8000, 16'd1); u4.i_tag = 8'h33; u4.i_valid = 1'b1;
    tick();
    s4.i_valid = 1'b0; u4.i_valid = 1'b0;
    tick();
    chk("sgn_data", s4.o_data, 16'h0001);
    chk("uns_valid", u4.o_valid, 1);
    chk("uns_data", u4.o_data, 16'h8000);
    chk("uns_tag", u4.o_tag, 8'h33);
`ifdef MAX_ARGMAX_EN
    chk("sgn_index", s4.o_index, 0);
    chk("uns_index", u4.o_index, 1);
`endif

    // Ties, back to back
    s4.i_data = pack4(16'd5, 16'd5, 16'd5, 16'd5); s4.i_tag = 8'h44; s4.i_valid = 1'b1;
    tick();
    s4.i_data = pack4(16'd9, 16'd9, 16'd1, 16'd1); s4.i_tag = 8'h55;
    tick();
    s4.i_valid = 1'b0;
    chk("tie_all_data", s4.o_data, 16'd5);
    chk("tie_all_tag", s4.o_tag, 8'h44);
`ifdef MAX_ARGMAX_EN
    chk("tie_all_index", s4.o_index, 0);
`endif
    tick();
    chk("tie_hi_valid", s4.o_valid, 1);
    chk("tie_hi_data", s4.o_data, 16'd9);
    chk("tie_hi_tag", s4.o_tag, 8'h55);
`ifdef MAX_ARGMAX_EN
    chk("tie_hi_index", s4.o_index, 2);
`endif

    // Five channels, three-stage latency
    f5.i_data = {16'd100, 16'd1, 16'd1, 16'd1, 16'd1}; f5.i_tag = 8'h66; f5.i_valid = 1'b1;
    tick();
    f5.i_valid = 1'b0;
    tick();
    chk("f5_lat_early", f5.o_valid, 0);
    tick();
    chk("f5_valid", f5.o_valid, 1);
    chk("f5_data", f5.o_data, 16'd100);
    chk("f5_tag", f5.o_tag, 8'h66);
`ifdef MAX_ARGMAX_EN
    chk("f5_index", f5.o_index, 4);
`endif
    f5.i_data = {5{16'h8000}}; f5.i_tag = 8'h77; f5.i_valid = 1'b1;
    tick();
    f5.i_valid = 1'b0;
    tick();
    tick();
    chk("f5_min_data", f5.o_data, 16'h8000);
`ifdef MAX_ARGMAX_EN
    chk("f5_min_index", f5.o_index, 0);
`endif

    // Streaming 8 samples with o_ready pattern 1,0,0,1
    sent = 0; rcvd = 0; cyc = 0; stall_prev = 1'b0; held_d = '0; held_t = '0;
    while (rcvd < 8 && cyc < 200) begin
      s4.o_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      if (sent < 8) begin
        s4.i_valid = 1'b1; s4.i_data = vec[sent]; s4.i_tag = 8'hA0 + 8'(sent);
      end else begin
        s4.i_valid = 1'b0;
      end
      #1;
      exp_rdy = !(s4.o_valid && !s4.o_ready);
      chk("strm_i_ready", s4.i_ready, exp_rdy);
      if (stall_prev) begin
        chk("strm_hold_valid", s4.o_valid, 1);
        chk("strm_hold_data", s4.o_data, held_d);
        chk("strm_hold_tag", s4.o_tag, held_t);
      end
      if (s4.o_valid && s4.o_ready) begin
        if (q_d.size() == 0) begin
          chk("strm_spurious", 1, 0);
        end else begin
          chk("strm_data", s4.o_data, q_d.pop_front());
          chk("strm_tag", s4.o_tag, q_t.pop_front());
`ifdef MAX_ARGMAX_EN
          chk("strm_index", s4.o_index, q_i.pop_front());
`else
          void'(q_i.pop_front());
`endif
        end
        rcvd++;
      end
      stall_prev = s4.o_valid && !s4.o_ready;
      held_d = s4.o_data; held_t = s4.o_tag;
      if (s4.i_valid && s4.i_ready) begin
        q_d.push_back(exp_d[sent]);
        q_t.push_back(8'hA0 + 8'(sent));
        q_i.push_back(exp_i[sent]);
        sent++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("strm_count", rcvd, 8);
    chk("strm_drain", q_d.size(), 0);

    // Mid-stream reset discards in-flight samples
    s4.o_ready = 1'b0;
    s4.i_valid = 1'b1; s4.i_data = vec[0]; s4.i_tag = 8'hB0;
    tick();
    s4.i_data = vec[1]; s4.i_tag = 8'hB1;
    tick();
    s4.i_valid = 1'b0;
    chk("pre_rst_valid", s4.o_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", s4.o_valid, 0);
    chk("mid_rst_i_ready", s4.i_ready, 1);
    tick();
    rst_n = 1'b1;
    s4.o_ready = 1'b1;
    repeat (4) begin
      tick();
      chk("no_stale", s4.o_valid, 0);
    end
    s4.i_valid = 1'b1; s4.i_data = vec[7]; s4.i_tag = 8'hC7;
    tick();
    s4.i_valid = 1'b0;
    tick();
    chk("post_rst_valid", s4.o_valid, 1);
    chk("post_rst_data", s4.o_data, 16'd400);
    chk("post_rst_tag", s4.o_tag, 8'hC7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
